tm_program_loader: RTL

Host-side driver for the TuringMachine programming and stepping interface. It accepts transition-table symbols from a host over a valid/ready handshake and serialises each one onto `input_data` with correctly timed `Next` strobes. After the last symbol it issues the `Done` strobe, then issues single-step `Next` pulses on request and reports step count and halt. It sits between the host/ROM sequencer and the TuringMachine core, driving the core's `input_data`, `Next` and `Done` and observing its `direction` and `next_state_out`.

---
 rtl/tm_pkg.sv | 28 ++
 rtl/tm_pulse_timer.sv | 34 +++
 rtl/tm_program_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tm_pkg.sv
// Shared types and defaults for the TuringMachine program loader: FSM state
// enum, core direction encodings and default strobe timing.
package tm_pkg;

  typedef enum logic [3:0] {
    LOAD_IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE_HI,
    DONE_GAP,
    READY,
    STEP_HI,
    STEP_GAP,
    SAMPLE,
    HALTED
  } tm_state_e;

  localparam logic [1:0] TM_DIR_LEFT  = 2'b01;
  localparam logic [1:0] TM_DIR_RIGHT = 2'b10;
  localparam logic [1:0] TM_DIR_HALT  = 2'b11;

  localparam int TM_SETUP_CYC = 3;
  localparam int TM_HOLD_CYC  = 2;
  localparam int TM_GAP_CYC   = 2;
  localparam int TM_TMR_W     = 8;

endpackage

// File: rtl/tm_pulse_timer.sv
// Loadable down-counter shared by the setup, hold and gap phases; counts to
// zero and parks there, with 'zero' flagging the final cycle of a phase.
module tm_pulse_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tm_program_loader.sv
// Host-side TuringMachine programming/stepping driver. Optional macro
// TM_LOADER_AUTORUN_EN makes READY start a step by itself until halt.
//
// state     | meaning
// LOAD_IDLE | waiting for a host symbol (sym_ready=1)
// SETUP     | input_data settling before Next
// PULSE     | Next high for one program symbol
// GAP       | Next low after a symbol pulse
// DONE_HI   | Done high after the last symbol
// DONE_GAP  | Done low, then loaded
// READY     | loaded, waiting for a step request
// STEP_HI   | Next high for one machine step
// STEP_GAP  | Next low while the core settles
// SAMPLE    | capture tm_state / tm_dir, count the step
// HALTED    | core reported halt; terminal until Reset
module tm_program_loader
  import tm_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int SETUP_CYC = TM_SETUP_CYC,
  parameter int HOLD_CYC  = TM_HOLD_CYC,
  parameter int GAP_CYC   = TM_GAP_CYC,
  parameter int STEP_W    = 16
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              sym_valid,
  input  logic [DATA_W-1:0] sym_data,
  input  logic              sym_last,
  output logic              sym_ready,
  input  logic              step_req,
  input  logic [5:0]        tm_state,
  input  logic [1:0]        tm_dir,
  output logic [DATA_W-1:0] input_data,
  output logic              Next,
  output logic              Done,
  output logic              loaded,
  output logic              halted,
  output logic [STEP_W-1:0] step_count,
  output logic [5:0]        last_state
);

`ifdef TM_LOADER_AUTORUN_EN
  localparam bit AUTORUN = 1'b1;
`else
  localparam bit AUTORUN = 1'b0;
`endif

  // SETUP runs one extra cycle for the input_data register stage. Between
  // symbols the last gap cycle overlaps LOAD_IDLE, so GAP itself is one short.
  localparam logic [TM_TMR_W-1:0] LD_SETUP    = TM_TMR_W'(SETUP_CYC);
  localparam logic [TM_TMR_W-1:0] LD_HOLD     = TM_TMR_W'(HOLD_CYC - 1);
  localparam logic [TM_TMR_W-1:0] LD_GAP_FULL = TM_TMR_W'(GAP_CYC - 1);
  localparam logic [TM_TMR_W-1:0] LD_GAP_SYM  = TM_TMR_W'(GAP_CYC - 2);
  localparam bit                  GAP_SKIP    = (GAP_CYC == 1);

  tm_state_e           state_q, state_d;
  logic                tmr_load, tmr_zero;
  logic [TM_TMR_W-1:0] tmr_val;
  logic                accept, step_start;

  logic              sym_ready_q, sym_ready_d;
  logic              next_q, next_d;
  logic              done_q, done_d;
  logic              loaded_q, loaded_d;
  logic              halted_q, halted_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] input_data_q, input_data_d;
  logic [STEP_W-1:0] step_count_q, step_count_d;
  logic [5:0]        last_state_q, last_state_d;

  assign accept     = (state_q == LOAD_IDLE) && sym_valid && sym_ready_q;
  assign step_start = step_req || AUTORUN;

  tm_pulse_timer #(.W(TM_TMR_W)) u_timer (
    .clock    (clock),
    .Reset    (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= LOAD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = LD_HOLD;
    unique case (state_q)
      LOAD_IDLE: if (accept) begin
        state_d = SETUP; tmr_load = 1'b1; tmr_val = LD_SETUP;
      end
      SETUP: if (tmr_zero) begin
        state_d = PULSE; tmr_load = 1'b1; tmr_val = LD_HOLD;
      end
      PULSE: if (tmr_zero) begin
        if (!last_q && GAP_SKIP) begin
          state_d = LOAD_IDLE;
        end else begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = last_q ? LD_GAP_FULL : LD_GAP_SYM;
        end
      end
      GAP: if (tmr_zero) begin
        if (last_q) begin
          state_d = DONE_HI; tmr_load = 1'b1; tmr_val = LD_HOLD;
        end else begin
          state_d = LOAD_IDLE;
        end
      end
      DONE_HI: if (tmr_zero) begin
        state_d = DONE_GAP; tmr_load = 1'b1; tmr_val = LD_GAP_FULL;
      end
      DONE_GAP: if (tmr_zero) state_d = READY;
      READY: if (step_start) begin
        state_d = STEP_HI; tmr_load = 1'b1; tmr_val = LD_HOLD;
      end
      STEP_HI: if (tmr_zero) begin
        state_d = STEP_GAP; tmr_load = 1'b1; tmr_val = LD_GAP_FULL;
      end
      STEP_GAP: if (tmr_zero) state_d = SAMPLE;
      // Autorun chains straight into the next step to keep a 5-cycle cadence.
      SAMPLE: begin
        if (tm_dir == TM_DIR_HALT) begin
          state_d = HALTED;
        end else if (AUTORUN) begin
          state_d = STEP_HI; tmr_load = 1'b1; tmr_val = LD_HOLD;
        end else begin
          state_d = READY;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = LOAD_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they come out glitch-free.
  always_comb begin
    sym_ready_d  = (state_d == LOAD_IDLE);
    next_d       = (state_d == PULSE) || (state_d == STEP_HI);
    done_d       = (state_d == DONE_HI);
    loaded_d     = state_d inside {READY, STEP_HI, STEP_GAP, SAMPLE, HALTED};
    input_data_d = accept ? sym_data : input_data_q;
    last_d       = accept ? sym_last : last_q;
    step_count_d = step_count_q;
    last_state_d = last_state_q;
    halted_d     = halted_q;
    if (state_q == SAMPLE) begin
      if (step_count_q != '1) step_count_d = step_count_q + STEP_W'(1);
      last_state_d = tm_state;
      if (tm_dir == TM_DIR_HALT) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      sym_ready_q  <= 1'b0;
      next_q       <= 1'b0;
      done_q       <= 1'b0;
      loaded_q     <= 1'b0;
      halted_q     <= 1'b0;
      last_q       <= 1'b0;
      input_data_q <= '0;
      step_count_q <= '0;
      last_state_q <= '0;
    end else begin
      sym_ready_q  <= sym_ready_d;
      next_q       <= next_d;
      done_q       <= done_d;
      loaded_q     <= loaded_d;
      halted_q     <= halted_d;
      last_q       <= last_d;
      input_data_q <= input_data_d;
      step_count_q <= step_count_d;
      last_state_q <= last_state_d;
    end
  end

  assign sym_ready  = sym_ready_q;
  assign Next       = next_q;
  assign Done       = done_q;
  assign loaded     = loaded_q;
  assign halted     = halted_q;
  assign input_data = input_data_q;
  assign step_count = step_count_q;
  assign last_state = last_state_q;

endmodule
